// File: rtl/versioned_store.sv
// versioned_store: DEPTH-entry (version, data) store. A read returns the entry
// with the greatest stored version strictly below the requested version.
// Writes update in place, allocate a free slot, evict the oldest version, or
// are dropped when they are older than everything held in a full store.
module versioned_store #(
  parameter int DATA_W = 32,
  parameter int VER_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       wrValid,
  input  logic [VER_W-1:0]           wrVersion,
  input  logic [DATA_W-1:0]          wrData,
  output logic                       wrDrop,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       rdValid,
  output logic                       rdReady,
  input  logic [VER_W-1:0]           rdVersion,
  output logic                       rspValid,
  input  logic                       rspReady,
  output logic                       rspHit,
  output logic [VER_W-1:0]           rspVersion,
  output logic [DATA_W-1:0]          rspData
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Slot contents, gathered from the per-slot registers below
  logic [DEPTH-1:0]  slotValid;
  logic [VER_W-1:0]  slotVer  [DEPTH];
  logic [DATA_W-1:0] slotData [DEPTH];

  // Write decision signals
  logic          anyMatch, anyFree, minFound;
  logic [IW-1:0] matchIdx, freeIdx, minIdx;
  logic [VER_W-1:0] minVer;
  logic          wrEn, wrAlloc, wrDiscard;
  logic [IW-1:0] wrIdx;

  // Lookup result
  logic              lkHit;
  logic [VER_W-1:0]  lkVer;
  logic [DATA_W-1:0] lkData;

  logic [CW-1:0] countReg;
  logic          wrDropReg;
  logic          rspValidReg, rspHitReg;
  logic [VER_W-1:0]  rspVersionReg;
  logic [DATA_W-1:0] rspDataReg;
  logic          rdAccept;

  // Scan slots for a version match, the lowest free slot and the oldest version
  always_comb begin
    anyMatch = 1'b0;
    matchIdx = '0;
    anyFree  = 1'b0;
    freeIdx  = '0;
    minFound = 1'b0;
    minVer   = '0;
    minIdx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slotValid[i] && slotVer[i] == wrVersion) begin
        anyMatch = 1'b1;
        matchIdx = IW'(i);
      end
      if (!slotValid[i] && !anyFree) begin
        anyFree = 1'b1;
        freeIdx = IW'(i);
      end
      if (slotValid[i] && (!minFound || slotVer[i] < minVer)) begin
        minFound = 1'b1;
        minVer   = slotVer[i];
        minIdx   = IW'(i);
      end
    end
  end

  // Pick the write action: overwrite, allocate, evict oldest, or discard
  always_comb begin
    wrEn      = 1'b0;
    wrIdx     = '0;
    wrAlloc   = 1'b0;
    wrDiscard = 1'b0;
    if (wrValid && !clear) begin
      if (anyMatch) begin
        wrEn  = 1'b1;
        wrIdx = matchIdx;
      end else if (anyFree) begin
        wrEn    = 1'b1;
        wrIdx   = freeIdx;
        wrAlloc = 1'b1;
      end else if (wrVersion > minVer) begin
        wrEn  = 1'b1;
        wrIdx = minIdx;
      end else begin
        wrDiscard = 1'b1;
      end
    end
  end

  // Lookup: newest valid version strictly below rdVersion (versions are unique)
  always_comb begin
    lkHit  = 1'b0;
    lkVer  = '0;
    lkData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slotValid[i] && slotVer[i] < rdVersion && (!lkHit || slotVer[i] > lkVer)) begin
        lkHit  = 1'b1;
        lkVer  = slotVer[i];
        lkData = slotData[i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gSlot
      logic              validReg;
      logic [VER_W-1:0]  verReg;
      logic [DATA_W-1:0] dataReg;

      // Per-slot storage: clear invalidates, a selected write loads the entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          validReg <= 1'b0;
          verReg   <= '0;
          dataReg  <= '0;
        end else if (clear) begin
          validReg <= 1'b0;
        end else if (wrEn && wrIdx == IW'(gi)) begin
          validReg <= 1'b1;
          verReg   <= wrVersion;
          dataReg  <= wrData;
        end
      end

      assign slotValid[gi] = validReg;
      assign slotVer[gi]   = verReg;
      assign slotData[gi]  = dataReg;
    end
  endgenerate

  // Occupancy count and one-cycle drop indication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      countReg  <= '0;
      wrDropReg <= 1'b0;
    end else begin
      wrDropReg <= wrDiscard;
      if (clear) begin
        countReg <= '0;
      end else if (wrAlloc) begin
        countReg <= countReg + CW'(1);
      end
    end
  end

  assign rdReady  = !rspValidReg || rspReady;
  assign rdAccept = rdValid && rdReady;

  // Response register: load on accept, retire when consumed, hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rspValidReg   <= 1'b0;
      rspHitReg     <= 1'b0;
      rspVersionReg <= '0;
      rspDataReg    <= '0;
    end else if (rdAccept) begin
      rspValidReg   <= 1'b1;
      rspHitReg     <= lkHit;
      rspVersionReg <= lkVer;
      rspDataReg    <= lkData;
    end else if (rspValidReg && rspReady) begin
      rspValidReg <= 1'b0;
    end
  end

  assign wrDrop     = wrDropReg;
  assign count      = countReg;
  assign rspValid   = rspValidReg;
  assign rspHit     = rspHitReg;
  assign rspVersion = rspVersionReg;
  assign rspData    = rspDataReg;

endmodule

// File: tb/tb_versioned_store.sv
// tb_versioned_store: directed and random stimulus against a map-based model
// of the store (version -> data, bounded to DEPTH entries).
module tb_versioned_store;

  localparam int DATA_W = 32;
  localparam int VER_W  = 4;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              wrValid;
  logic [VER_W-1:0]  wrVersion;
  logic [DATA_W-1:0] wrData;
  logic              wrDrop;
  logic [CW-1:0]     count;
  logic              rdValid;
  logic              rdReady;
  logic [VER_W-1:0]  rdVersion;
  logic              rspValid;
  logic              rspReady;
  logic              rspHit;
  logic [VER_W-1:0]  rspVersion;
  logic [DATA_W-1:0] rspData;

  versioned_store #(.DATA_W(DATA_W), .VER_W(VER_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .wrValid(wrValid), .wrVersion(wrVersion), .wrData(wrData), .wrDrop(wrDrop),
    .count(count),
    .rdValid(rdValid), .rdReady(rdReady), .rdVersion(rdVersion),
    .rspValid(rspValid), .rspReady(rspReady), .rspHit(rspHit),
    .rspVersion(rspVersion), .rspData(rspData)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: committed entries keyed by version
  logic [DATA_W-1:0] model [int unsigned];

  // Expected response register state
  logic              eRspValid = 1'b0;
  logic              eHit = 1'b0;
  logic [VER_W-1:0]  eVer = '0;
  logic [DATA_W-1:0] eData = '0;
  logic              eDrop = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelWrite(input int unsigned v, input logic [DATA_W-1:0] d, output bit drop);
    int unsigned oldest;
    drop = 1'b0;
    if (model.exists(v) || model.size() < DEPTH) begin
      model[v] = d;
    end else begin
      void'(model.first(oldest));
      if (v > oldest) begin
        model.delete(oldest);
        model[v] = d;
      end else begin
        drop = 1'b1;
      end
    end
  endtask

  task automatic modelLookup(input int rv, output bit hit, output int unsigned hv,
                             output logic [DATA_W-1:0] hd);
    hit = 1'b0; hv = 0; hd = '0;
    for (int v = rv - 1; v >= 0; v--) begin
      if (model.exists(v)) begin
        hit = 1'b1; hv = v; hd = model[v];
        break;
      end
    end
  endtask

  task automatic checkOutputs(input string tag);
    check({tag, ".rspValid"},   64'(rspValid),   64'(eRspValid));
    check({tag, ".rspHit"},     64'(rspHit),     64'(eHit));
    check({tag, ".rspVersion"}, 64'(rspVersion), 64'(eVer));
    check({tag, ".rspData"},    64'(rspData),    64'(eData));
    check({tag, ".wrDrop"},     64'(wrDrop),     64'(eDrop));
    check({tag, ".count"},      64'(count),      64'(model.size()));
  endtask

  // One clock cycle: drive inputs, check rdReady, advance model, check outputs
  task automatic doCycle(input string tag, input bit wv, input int unsigned wver,
                         input logic [DATA_W-1:0] wd, input bit clr, input bit rv,
                         input int unsigned rver, input bit rr);
    bit acc, hit, drop;
    int unsigned hv;
    logic [DATA_W-1:0] hd;
    wrValid = wv; wrVersion = VER_W'(wver); wrData = wd; clear = clr;
    rdValid = rv; rdVersion = VER_W'(rver); rspReady = rr;
    #1;
    check({tag, ".rdReady"}, 64'(rdReady), 64'(!eRspValid || rr));
    acc = rv && (!eRspValid || rr);
    hit = 1'b0; hv = 0; hd = '0;
    if (acc) modelLookup(int'(rver), hit, hv, hd);
    drop = 1'b0;
    if (clr) model.delete();
    else if (wv) modelWrite(wver, wd, drop);
    @(posedge clk); #1;
    if (acc) begin
      eRspValid = 1'b1; eHit = hit; eVer = VER_W'(hv); eData = hd;
    end else if (eRspValid && rr) begin
      eRspValid = 1'b0;
    end
    eDrop = drop;
    checkOutputs(tag);
    $display("[TB] %s wr=%0b/%0d/%0h clr=%0b rd=%0b/%0d rr=%0b -> rsp v=%0b h=%0b ver=%0d d=%0h cnt=%0d drop=%0b",
             tag, wv, wver, wd, clr, rv, rver, rr, rspValid, rspHit, rspVersion, rspData, count, wrDrop);
  endtask

  task automatic wr(input string tag, input int unsigned v, input logic [DATA_W-1:0] d);
    doCycle(tag, 1'b1, v, d, 1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic rd(input string tag, input int unsigned v);
    doCycle(tag, 1'b0, 0, '0, 1'b0, 1'b1, v, 1'b1);
  endtask

  task automatic clr(input string tag);
    doCycle(tag, 1'b0, 0, '0, 1'b1, 1'b0, 0, 1'b1);
  endtask

  task automatic resetModel();
    model.delete();
    eRspValid = 1'b0; eHit = 1'b0; eVer = '0; eData = '0; eDrop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; wrValid = 1'b0; wrVersion = '0; wrData = '0;
    rdValid = 1'b0; rdVersion = '0; rspReady = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1 checkOutputs("reset");

    // Basic lookup
    wr("basic.w1", 1, 32'hA);
    wr("basic.w3", 3, 32'hB);
    wr("basic.w5", 5, 32'hC);
    rd("basic.r4", 4);
    check("basic.r4.data", 64'(rspData), 64'hB);
    rd("basic.r6", 6);
    check("basic.r6.ver", 64'(rspVersion), 64'd5);
    rd("basic.r1", 1);
    check("basic.r1.hit", 64'(rspHit), 64'd0);
    rd("basic.r0", 0);

    // Eviction and drop
    clr("evict.clr");
    wr("evict.w2", 2, 32'h2);
    wr("evict.w4", 4, 32'h4);
    wr("evict.w6", 6, 32'h6);
    wr("evict.w8", 8, 32'h8);
    wr("evict.w9", 9, 32'h9);
    check("evict.count", 64'(count), 64'd4);
    rd("evict.r3", 3);
    check("evict.r3.hit", 64'(rspHit), 64'd0);
    wr("evict.w1", 1, 32'h1);
    check("evict.drop", 64'(wrDrop), 64'd1);
    rd("evict.r5", 5);
    check("evict.drop.end", 64'(wrDrop), 64'd0);
    rd("evict.r15", 15);

    // Overwrite
    clr("ovw.clr");
    wr("ovw.a", 3, 32'h11);
    wr("ovw.b", 3, 32'h22);
    check("ovw.count", 64'(count), 64'd1);
    rd("ovw.r4", 4);
    check("ovw.data", 64'(rspData), 64'h22);

    // Backpressure: response stalled for three cycles, then drained with a new accept
    wr("bp.w7", 7, 32'h70);
    doCycle("bp.acc", 1'b0, 0, '0, 1'b0, 1'b1, 8, 1'b0);
    for (int i = 0; i < 3; i++) doCycle("bp.hold", 1'b0, 0, '0, 1'b0, 1'b1, 4, 1'b0);
    doCycle("bp.rel", 1'b0, 0, '0, 1'b0, 1'b1, 4, 1'b1);
    check("bp.rel.data", 64'(rspData), 64'h22);
    doCycle("bp.drain", 1'b0, 0, '0, 1'b0, 1'b0, 0, 1'b1);

    // Same-cycle hazards
    clr("haz.clr");
    wr("haz.w5", 5, 32'h55);
    doCycle("haz.rw", 1'b1, 7, 32'h77, 1'b0, 1'b1, 8, 1'b1);
    check("haz.old", 64'(rspData), 64'h55);
    rd("haz.r8", 8);
    check("haz.new", 64'(rspData), 64'h77);
    wr("haz.w2", 2, 32'h22);
    wr("haz.w3", 3, 32'h33);
    doCycle("haz.clrwr", 1'b1, 9, 32'h99, 1'b1, 1'b0, 0, 1'b1);
    check("haz.clrwr.count", 64'(count), 64'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      doCycle("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom,
              ($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)),
              $urandom_range(0, 15), ($urandom_range(0, 3) != 0));
    end

    // Async reset with a pending response and three entries
    clr("ar.clr");
    wr("ar.w1", 1, 32'h101);
    wr("ar.w2", 2, 32'h102);
    wr("ar.w3", 3, 32'h103);
    doCycle("ar.pend", 1'b0, 0, '0, 1'b0, 1'b1, 4, 1'b0);
    check("ar.pre.count", 64'(count), 64'd3);
    #2 rst = 1'b1;
    #1;
    resetModel();
    checkOutputs("ar.async");
    #2 rst = 1'b0;
    rd("ar.after", 4);
    check("ar.after.hit", 64'(rspHit), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    testsFailed++;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $fatal(1, "timeout");
  end

endmodule
